// File: rtl/factory_test_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : factory_test_seq_pkg
// Description : Shared types and constants for the factory test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package factory_test_seq_pkg;

    localparam int NUM_STEPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CHK_LOGIC = 2'd0,
        CHK_LOOP  = 2'd1,
        CHK_BIAS  = 2'd2
    } check_t;

    typedef struct packed {
        logic tie_val;
        logic oe_val;
        logic loop_drv;
        logic ena_3v3_n;
        logic ena_1v8_n;
    } step_drive_t;

    // Both bias rails off, no tie-off or loopback stimulus.
    localparam step_drive_t c_safe_drive = '{
        tie_val:   1'b0,
        oe_val:    1'b0,
        loop_drv:  1'b0,
        ena_3v3_n: 1'b1,
        ena_1v8_n: 1'b1
    };

endpackage
`default_nettype wire

// File: rtl/factory_test_step_rom.sv
`default_nettype none
// ============================================================================
// Module      : factory_test_step_rom
// Description : Step index to drive pattern, check type and window select.
// Revision    : 1.0 - initial release
// ============================================================================
module factory_test_step_rom
    import factory_test_seq_pkg::*;
(
    input  logic [2:0]  step_idx,
    output step_drive_t drive,
    output check_t      chk,
    output logic        win_bias
);

    always_comb begin
        drive    = c_safe_drive;
        chk      = CHK_LOGIC;
        win_bias = 1'b0;
        case (step_idx)
            3'd0: drive = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            3'd1: drive = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            3'd2: drive = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            3'd3: drive = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            3'd4: begin
                drive = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
                chk   = CHK_LOOP;
            end
            3'd5: begin
                drive = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
                chk   = CHK_LOOP;
            end
            // Only one bias rail is ever enabled per step.
            3'd6: begin
                drive    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                chk      = CHK_BIAS;
                win_bias = 1'b1;
            end
            3'd7: begin
                drive    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                chk      = CHK_BIAS;
                win_bias = 1'b1;
            end
            default: drive = c_safe_drive;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/factory_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : factory_test_sequencer
// Description : Steps a device under test through tie-off, loopback and bias
//               checks, accumulating a per-step failure mask.
// Revision    : 1.0 - initial release
// ============================================================================
module factory_test_sequencer
    import factory_test_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int BIAS_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       ena_3v3_n,
    output logic       ena_1v8_n,
    output logic       tie_val,
    output logic       oe_val,
    output logic       loop_drv,
    input  logic [7:0] uo_obs,
    input  logic [7:0] uio_obs,
    input  logic [7:0] uio_oe_obs,
    input  logic       loop_sense,
    input  logic       sense_ok,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [2:0] step
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > BIAS_CYCLES) ? SETTLE_CYCLES : BIAS_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] c_settle_term = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_bias_term   = CNT_W'(BIAS_CYCLES - 1);
    localparam logic [2:0]       c_last_step   = 3'(NUM_STEPS - 1);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_step, w_rom_idx;
    step_drive_t      r_drv, w_rom_drv;
    check_t           r_chk, w_rom_chk;
    logic             r_win_bias, w_rom_win;
    logic             r_busy, r_done, r_pass;
    logic [7:0]       r_fail_mask, w_fail_mask_next;
    logic             w_step_fail, w_term_hit;

    // Entering step 0 from IDLE, or step+1 from CHECK, loads the next pattern.
    factory_test_step_rom u_rom (
        .step_idx (w_rom_idx),
        .drive    (w_rom_drv),
        .chk      (w_rom_chk),
        .win_bias (w_rom_win)
    );

    assign w_term_hit = (r_cnt == (r_win_bias ? c_bias_term : c_settle_term));

    always_comb begin
        w_step_fail = 1'b0;
        case (r_chk)
            CHK_LOGIC: w_step_fail = !((uo_obs     == {8{r_drv.tie_val}}) &&
                                       (uio_obs    == {8{r_drv.tie_val}}) &&
                                       (uio_oe_obs == {8{r_drv.oe_val}}));
            CHK_LOOP:  w_step_fail = (loop_sense != r_drv.loop_drv);
            CHK_BIAS:  w_step_fail = !sense_ok;
            default:   w_step_fail = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_rom_idx        = 3'd0;
        w_fail_mask_next = r_fail_mask;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_SETTLE;
            ST_SETTLE: if (w_term_hit) w_state_next = ST_CHECK;
            ST_CHECK: begin
                w_rom_idx        = r_step + 3'd1;
                w_fail_mask_next = r_fail_mask | ({7'd0, w_step_fail} << r_step);
                w_state_next     = (r_step == c_last_step) ? ST_IDLE : ST_SETTLE;
            end
            default:   w_state_next = ST_IDLE;
        endcase
        if (abort) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_step      <= 3'd0;
            r_drv       <= c_safe_drive;
            r_chk       <= CHK_LOGIC;
            r_win_bias  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 8'd0;
        end else if (abort) begin
            // Failure history survives an abort for post-mortem readout.
            r_cnt      <= '0;
            r_step     <= 3'd0;
            r_drv      <= c_safe_drive;
            r_chk      <= CHK_LOGIC;
            r_win_bias <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt       <= '0;
                        r_step      <= 3'd0;
                        r_drv       <= w_rom_drv;
                        r_chk       <= w_rom_chk;
                        r_win_bias  <= w_rom_win;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_mask <= 8'd0;
                    end
                end
                ST_SETTLE: r_cnt <= r_cnt + CNT_W'(1);
                ST_CHECK: begin
                    r_cnt       <= '0;
                    r_fail_mask <= w_fail_mask_next;
                    if (r_step == c_last_step) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_fail_mask_next == 8'd0);
                        r_drv  <= c_safe_drive;
                    end else begin
                        r_step     <= r_step + 3'd1;
                        r_drv      <= w_rom_drv;
                        r_chk      <= w_rom_chk;
                        r_win_bias <= w_rom_win;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tie_val   = r_drv.tie_val;
    assign oe_val    = r_drv.oe_val;
    assign loop_drv  = r_drv.loop_drv;
    assign ena_3v3_n = r_drv.ena_3v3_n;
    assign ena_1v8_n = r_drv.ena_1v8_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign step      = r_step;

endmodule
`default_nettype wire

// File: doc/factory_test_sequencer.md
FACTORY_TEST_SEQUENCER -- requirements
Module: factory_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles each logic/loopback step is driven before sampling (>=1).
REQ-002 SHALL have parameter BIAS_CYCLES, default 1024: cycles each bias-enable window is held before sampling (>=1).
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge
  rst  in  1  synchronous, active-high reset
  start  in  1  begin sequence (sampled in IDLE only)
  abort  in  1  terminate sequence, safe-state outputs
  ena_3v3_n  out  1  3v3 bias enable to DUT, active low
  ena_1v8_n  out  1  1v8 bias enable to DUT, active low
  tie_val  out  1  drives DUT tie-off data select
  oe_val  out  1  drives DUT tie-off enable select
  loop_drv  out  1  drive into DUT analog loopback
  uo_obs  in  8  DUT dedicated outputs observed
  uio_obs  in  8  DUT bidir outputs observed
  uio_oe_obs  in  8  DUT bidir enables observed
  loop_sense  in  1  loopback return, thresholded
  sense_ok  in  1  external power-sense comparator OK
  busy  out  1  sequence running
  done  out  1  sequence completed (sticky)
  pass  out  1  done and no failures
  fail_mask  out  8  bit n set = step n failed
  step  out  3  current step index

Function
REQ-004 SHALL implement states IDLE, SETTLE, CHECK; SETTLE holds step drives while counter runs, CHECK is one cycle of comparison.
REQ-005 SHALL, in IDLE on start=1, clear done/pass/fail_mask, set step=0, enter SETTLE; busy=1 from next cycle.
REQ-006 SHALL ignore start while busy=1.
REQ-007 SHALL, in SETTLE, count from 0 and enter CHECK after SETTLE_CYCLES cycles (steps 0-5) or BIAS_CYCLES cycles (steps 6-7).
REQ-008 SHALL drive per step (tie_val,oe_val,loop_drv,ena_3v3_n,ena_1v8_n): 0:(0,0,0,1,1) 1:(1,0,0,1,1) 2:(0,1,0,1,1) 3:(1,1,0,1,1) 4:(0,0,1,1,1) 5:(0,0,0,1,1) 6:(0,0,0,0,1) 7:(0,0,0,1,0); drives registered, valid from first SETTLE cycle.
REQ-009 SHALL, in CHECK for steps 0-3, set fail_mask[step] unless uo_obs=={8{tie_val}}, uio_obs=={8{tie_val}}, uio_oe_obs=={8{oe_val}}.
REQ-010 SHALL, in CHECK for step 4/5, set fail_mask[step] unless loop_sense==loop_drv; steps 6/7 fail unless sense_ok==1.
REQ-011 SHALL keep drives unchanged during CHECK; step increments and SETTLE re-enters on next cycle; counter restarts at 0.
REQ-012 SHALL, on CHECK of step 7, return to IDLE with busy=0, done=1, pass=(final fail_mask==0), all drives at safe values, in the same next cycle.
REQ-013 SHALL hold done, pass, fail_mask until next accepted start, abort, or rst.
REQ-014 SHALL, on abort=1 in any state, next cycle: IDLE, busy=0, done=0, pass=0, safe drives; fail_mask retained; abort dominates start in same cycle.
REQ-015 SHALL never assert ena_3v3_n=0 and ena_1v8_n=0 simultaneously.
REQ-016 SHALL size the counter $clog2(max(SETTLE_CYCLES,BIAS_CYCLES))+1 bits; no wrap before terminal count.

Reset
REQ-017 SHALL on rst=1: state IDLE, ena_3v3_n=1, ena_1v8_n=1, tie_val=0, oe_val=0, loop_drv=0, busy=0, done=0, pass=0, fail_mask=0, step=0, counter=0; rst dominates abort and start.
REQ-018 SHALL apply reset mid-sequence with no further checks; bias enables deasserted the cycle after rst samples high.

Structure
REQ-019 SHALL place state enum, NUM_STEPS=8, step-drive record type and safe-drive constant in package factory_test_seq_pkg.
REQ-020 SHALL use one combinational sub-module factory_test_step_rom: step index -> drive record, expected-check type, window select.

Verification (SETTLE_CYCLES=4, BIAS_CYCLES=8)
REQ-021 SHALL cover: ideal DUT model, start pulse -> done=1, pass=1, fail_mask=00 exactly 48 cycles after busy rises.
REQ-022 SHALL cover: uio_oe_obs stuck 00 -> fail_mask=0C, pass=0, done=1.
REQ-023 SHALL cover: loop_sense stuck 0 -> fail_mask=10; sense_ok=0 throughout -> fail_mask=C0.
REQ-024 SHALL cover: abort during step 6 -> next cycle ena_3v3_n=1, busy=0, done=0; subsequent start reruns full sequence to pass=1.
REQ-025 SHALL cover: start held high during run ignored; rst at step 3 -> all outputs at reset values next cycle; assertion that both enables never low together.
